// File: rtl/mul_tree_sched.sv
// Round-robin scheduler sharing one non-stallable pipelined multiplier among NREQ requesters.
// Each requester holds credits (in-flight + buffered) so every returning product has a FIFO slot.
module mul_tree_sched #(
  parameter int NREQ   = 4,
  parameter int RDEPTH = 4,
  parameter int TW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]    req_signed,
  output logic               mul_valid,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  output logic               mul_signed,
  output logic [TW-1:0]      mul_tag,
  input  logic               res_valid,
  input  logic [63:0]        res_data,
  input  logic [TW-1:0]      res_tag,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [64*NREQ-1:0] rsp_data,
  output logic               err
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is combinational from registered credit/pointer state, res_* can never be stalled.
  localparam int AW = $clog2(RDEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(RDEPTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(RDEPTH);

  logic [CW-1:0] r_cnt  [NREQ];
  logic [CW-1:0] r_infl [NREQ];
  logic [PW-1:0] r_wptr [NREQ];
  logic [PW-1:0] r_rptr [NREQ];
  logic [63:0]   r_mem  [NREQ][RDEPTH];
  logic [TW-1:0] r_ptr;
  logic          r_mul_valid;
  logic [31:0]   r_mul_a;
  logic [31:0]   r_mul_b;
  logic          r_mul_signed;
  logic [TW-1:0] r_mul_tag;
  logic          r_err;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_pop;
  logic [NREQ-1:0] w_wr;
  logic            w_hs;
  logic            w_res_ok;
  logic [TW-1:0]   w_gidx;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;
  logic            w_sel_signed;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_valid[i] && (r_cnt[i] < CMAX);
    end
  end

  // First eligible index at or after r_ptr, wrapping; nothing is granted while in reset.
  always_comb begin
    int idx;
    idx          = 0;
    w_grant      = '0;
    w_hs         = 1'b0;
    w_gidx       = '0;
    w_sel_a      = '0;
    w_sel_b      = '0;
    w_sel_signed = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_hs && !rst && w_elig[idx]) begin
        w_hs         = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = TW'(idx);
        w_sel_a      = req_a[32*idx +: 32];
        w_sel_b      = req_b[32*idx +: 32];
        w_sel_signed = req_signed[idx];
      end
    end
  end

  // A result is only accepted for a known tag that has an op outstanding.
  always_comb begin
    w_wr     = '0;
    w_res_ok = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_wr[i] = res_valid && (res_tag == TW'(i)) && (r_infl[i] != '0);
      if (w_wr[i]) w_res_ok = 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (r_wptr[i] != r_rptr[i]);
      if (rsp_valid[i]) rsp_data[64*i +: 64] = r_mem[i][r_rptr[i][AW-1:0]];
    end
  end

  assign w_pop      = rsp_valid & rsp_ready;
  assign req_ready  = w_grant;
  assign mul_valid  = r_mul_valid;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_signed = r_mul_signed;
  assign mul_tag    = r_mul_tag;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_mul_valid  <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_signed <= 1'b0;
      r_mul_tag    <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i]  <= '0;
        r_infl[i] <= '0;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      r_mul_valid <= w_hs;
      if (w_hs) begin
        r_mul_a      <= w_sel_a;
        r_mul_b      <= w_sel_b;
        r_mul_signed <= w_sel_signed;
        r_mul_tag    <= w_gidx;
        r_ptr        <= (w_gidx == TW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
      end
      if (res_valid && !w_res_ok) r_err <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        case ({w_grant[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
        case ({w_grant[i], w_wr[i]})
          2'b10:   r_infl[i] <= r_infl[i] + CW'(1);
          2'b01:   r_infl[i] <= r_infl[i] - CW'(1);
          default: r_infl[i] <= r_infl[i];
        endcase
        if (w_wr[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i]) r_rptr[i] <= r_rptr[i] + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible between the reset pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst && w_wr[i]) r_mem[i][r_wptr[i][AW-1:0]] <= res_data;
    end
  end

endmodule

// File: tb/tb_mul_tree_sched.sv
// Bench for mul_tree_sched: a 3-stage multiplier model closes the loop, and a per-requester
// queue model (values plus the cycle each becomes visible) predicts every output cycle by cycle.
module tb_mul_tree_sched;
  localparam int NREQ   = 4;
  localparam int RDEPTH = 4;
  localparam int TW     = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]    req_signed = '0;
  logic               mul_valid;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic               mul_signed;
  logic [TW-1:0]      mul_tag;
  logic               res_valid;
  logic [63:0]        res_data;
  logic [TW-1:0]      res_tag;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready = '0;
  logic [64*NREQ-1:0] rsp_data;
  logic               err;

  logic               inj_valid = 1'b0;
  logic [63:0]        inj_data = '0;
  logic [TW-1:0]      inj_tag = '0;
  logic [2:0]         p_v = '0;
  logic [63:0]        p_d [3];
  logic [TW-1:0]      p_t [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base;

  logic [63:0] exp_q [NREQ][$];
  int          due_q [NREQ][$];
  int          late_q[$];
  int          acc_cnt [NREQ];
  int          mptr = 0;
  logic        m_err = 1'b0;
  logic        m_mv = 1'b0;
  logic [31:0] m_ma = '0;
  logic [31:0] m_mb = '0;
  logic        m_ms = 1'b0;
  logic [TW-1:0] m_mt = '0;

  mul_tree_sched #(.NREQ(NREQ), .RDEPTH(RDEPTH), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_signed(req_signed),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
    .mul_tag(mul_tag),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .err(err)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // External multiplier: fixed 3-cycle latency from mul_valid to res_valid
  function automatic logic [63:0] hw_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa, xb;
    xa = {{32{s & a[31]}}, a};
    xb = {{32{s & b[31]}}, b};
    return xa * xb;
  endfunction

  always @(posedge clk) begin
    p_v    <= {p_v[1:0], mul_valid};
    p_d[0] <= hw_mul(mul_a, mul_b, mul_signed);
    p_d[1] <= p_d[0];
    p_d[2] <= p_d[1];
    p_t[0] <= mul_tag;
    p_t[1] <= p_t[0];
    p_t[2] <= p_t[1];
  end

  assign res_valid = inj_valid | p_v[2];
  assign res_data  = inj_valid ? inj_data : p_d[2];
  assign res_tag   = inj_valid ? inj_tag : p_t[2];

  // Reference arithmetic for the product a requester should receive
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = $urandom;
      req_b[32*i +: 32] = $urandom;
    end
    req_signed = NREQ'($urandom_range(0, 15));
  endtask

  // Reset mid-operation: anything whose result still reaches the DUT after reset is a late error.
  task automatic flush();
    for (int j = late_q.size() - 1; j >= 0; j--) if (late_q[j] < cyc + 2) late_q.delete(j);
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < due_q[i].size(); j++) if (due_q[i][j] >= cyc + 2) late_q.push_back(due_q[i][j]);
      exp_q[i].delete();
      due_q[i].delete();
    end
    m_err = 1'b0; mptr = 0; m_mv = 1'b0; m_ma = '0; m_mb = '0; m_ms = 1'b0; m_mt = '0;
  endtask

  // One clock: compare all outputs with the model at negedge, then advance the model.
  task automatic cycle();
    logic [NREQ-1:0]    e_ready, e_rv;
    logic [64*NREQ-1:0] e_rd;
    int g;
    @(negedge clk);
    for (int j = late_q.size() - 1; j >= 0; j--) begin
      if (late_q[j] <= cyc) begin m_err = 1'b1; late_q.delete(j); end
    end
    e_ready = '0;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mptr + k) % NREQ;
        if (g < 0 && req_valid[idx] && exp_q[idx].size() < RDEPTH) g = idx;
      end
    end
    if (g >= 0) e_ready[g] = 1'b1;
    e_rv = '0;
    e_rd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (exp_q[i].size() > 0 && due_q[i][0] <= cyc) begin
        e_rv[i] = 1'b1;
        e_rd[64*i +: 64] = exp_q[i][0];
      end
    end
    chk("req_ready", 256'(req_ready), 256'(e_ready));
    chk("mul_valid", 256'(mul_valid), 256'(m_mv));
    chk("mul_a", 256'(mul_a), 256'(m_ma));
    chk("mul_b", 256'(mul_b), 256'(m_mb));
    chk("mul_signed", 256'(mul_signed), 256'(m_ms));
    chk("mul_tag", 256'(mul_tag), 256'(m_mt));
    chk("rsp_valid", 256'(rsp_valid), 256'(e_rv));
    chk("rsp_data", 256'(rsp_data), 256'(e_rd));
    chk("err", 256'(err), 256'(m_err));
    for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) acc_cnt[i]++;
    if (rst) begin
      flush();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (e_rv[i] && rsp_ready[i]) begin
          void'(exp_q[i].pop_front());
          void'(due_q[i].pop_front());
        end
      end
      m_mv = (g >= 0);
      if (g >= 0) begin
        exp_q[g].push_back(ref_prod(req_a[32*g +: 32], req_b[32*g +: 32], req_signed[g]));
        due_q[g].push_back(cyc + 5);
        m_ma = req_a[32*g +: 32];
        m_mb = req_b[32*g +: 32];
        m_ms = req_signed[g];
        m_mt = TW'(g);
        mptr = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;

    // Reset state, with requests pending while reset is held
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    chk("rst_mul_valid", 256'(mul_valid), 256'(0));
    chk("rst_mul_a", 256'(mul_a), 256'(0));
    chk("rst_mul_b", 256'(mul_b), 256'(0));
    chk("rst_mul_tag", 256'(mul_tag), 256'(0));
    chk("rst_mul_signed", 256'(mul_signed), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_rsp_data", 256'(rsp_data), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    req_valid = '0;
    rst = 1'b0;

    // Single unsigned op on requester 1: 7*6
    req_a[63:32] = 32'd7;
    req_b[63:32] = 32'd6;
    req_signed = '0;
    req_valid = 4'b0010;
    #1;
    chk("single_t0_ready", 256'(req_ready), 256'(4'b0010));
    cycle();
    req_valid = '0;
    chk("single_t1_mul_valid", 256'(mul_valid), 256'(1));
    chk("single_t1_mul_tag", 256'(mul_tag), 256'(1));
    chk("single_t1_mul_a", 256'(mul_a), 256'(7));
    repeat (4) cycle();
    chk("single_t5_rsp_valid", 256'(rsp_valid[1]), 256'(1));
    chk("single_t5_rsp_data", 256'(rsp_data[127:64]), 256'(64'd42));
    rsp_ready = 4'b0010;
    cycle();
    rsp_ready = '0;
    chk("single_popped", 256'(rsp_valid), 256'(0));

    // Signed and unsigned -3 * 5 on requester 0
    req_a[31:0] = 32'hFFFF_FFFD;
    req_b[31:0] = 32'd5;
    req_signed = 4'b0001;
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("signed_prod", 256'(rsp_data[63:0]), 256'(64'hFFFF_FFFF_FFFF_FFF1));
    rsp_ready = 4'b0001;
    cycle();
    rsp_ready = '0;
    req_signed = 4'b0000;
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("unsigned_prod", 256'(rsp_data[63:0]), 256'(64'h4_FFFF_FFF1));
    rsp_ready = 4'b0001;
    cycle();
    rsp_ready = '0;

    // Fairness: all requesting continuously, every response consumed
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    rsp_ready = '1;
    req_valid = '1;
    for (int n = 0; n < 40; n++) begin
      rand_ops();
      cycle();
    end
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_count_%0d", i), 256'(acc_cnt[i]), 256'(10));
    repeat (8) cycle();

    // Credit exhaustion on requester 2
    base = acc_cnt[2];
    rsp_ready = '0;
    req_valid = 4'b0100;
    rand_ops();
    repeat (10) cycle();
    chk("credit_accepts", 256'(acc_cnt[2] - base), 256'(4));
    chk("credit_blocked", 256'(req_ready), 256'(0));
    base = acc_cnt[2];
    rsp_ready = 4'b0100;
    cycle();
    rsp_ready = '0;
    repeat (6) cycle();
    chk("credit_one_more", 256'(acc_cnt[2] - base), 256'(1));
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) cycle();

    // Random traffic: overlapping pops, grants and result writes
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom_range(0, 15));
      rsp_ready = NREQ'($urandom_range(0, 15));
      rand_ops();
      cycle();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (12) cycle();

    // Stray result for requester 3 with nothing outstanding
    inj_tag = 2'd3;
    inj_data = {$urandom, $urandom};
    inj_valid = 1'b1;
    late_q.push_back(cyc + 1);
    cycle();
    inj_valid = 1'b0;
    chk("stray_err", 256'(err), 256'(1));
    chk("stray_fifo3_empty", 256'(rsp_valid[3]), 256'(0));
    repeat (2) cycle();

    // Reset with two ops in flight; their late results must flag err and never appear
    req_valid = 4'b0011;
    rand_ops();
    repeat (2) cycle();
    req_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_err", 256'(err), 256'(0));
    chk("midrst_mul_valid", 256'(mul_valid), 256'(0));
    chk("midrst_rsp_valid", 256'(rsp_valid), 256'(0));
    repeat (6) cycle();
    chk("late_err", 256'(err), 256'(1));
    chk("late_not_delivered", 256'(rsp_valid), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_tree_sched.md
Name: mul_tree_sched

Overview:
- Round-robin scheduler that shares one pipelined 32x32 multiplier (Booth PP generator + 17-row pp_tree16x64 reduction + CPA) among NREQ requesters.
- Accepts operand requests, issues at most one multiply per cycle, and tags each issue with the requester index.
- Steers tagged results back into per-requester response FIFOs.
- Credit counting guarantees no result is ever lost, because the multiplier pipeline cannot stall.

Parameters:
- NREQ, 4, number of requesters (2..8)
- RDEPTH, 4, response FIFO depth per requester; also the max outstanding ops per requester (power of 2)
- TW, 2, tag width = clog2(NREQ)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  32*NREQ  operand A, slice i = requester i
- req_b  in  32*NREQ  operand B
- req_signed  in  NREQ  1 = signed x signed, 0 = unsigned
- mul_valid  out  1  issue to multiplier
- mul_a, mul_b  out  32 each  issued operands
- mul_signed  out  1  issued mode
- mul_tag  out  TW  issued requester index
- res_valid  in  1  multiplier result valid (fixed pipeline latency, no backpressure)
- res_data  in  64  product
- res_tag  in  TW  tag returned with product
- rsp_valid  out  NREQ  response FIFO non-empty
- rsp_ready  in  NREQ  response consume
- rsp_data  out  64*NREQ  head of FIFO i (show-ahead)
- err  out  1  sticky protocol error

Behaviour:
- Reset: req_ready=0, mul_valid=0, mul_a/mul_b/mul_tag/mul_signed=0, rsp_valid=0, rsp_data=0, err=0, all credits=0, all FIFOs empty, RR pointer=0.
- Reset mid-operation flushes all state. Results arriving after reset are dropped and flagged (see err).
- Credit: cnt[i] = in-flight ops + FIFO occupancy, range 0..RDEPTH.
  - Requester i is eligible iff req_valid[i] && cnt[i] < RDEPTH.
- Arbitration (combinational):
  - Grant the first eligible index at or after ptr, wrapping modulo NREQ.
  - req_ready[g]=1 for the granted index only; all others 0.
  - Handshake = req_valid & req_ready, same cycle.
  - On a grant, ptr <= g+1 mod NREQ. With no grant, ptr holds.
- Issue register:
  - The cycle after a handshake: mul_valid=1, with mul_a/mul_b/mul_signed taken from slice g and mul_tag=g.
  - With no handshake, mul_valid=0 and the data fields hold their last values.
  - Accept-to-issue latency is 1 cycle.
  - Sustained throughput is 1 op/cycle whenever any requester is eligible.
- Credit update per i:
  - +1 on issue-accept of i; -1 on rsp_valid[i]&rsp_ready[i].
  - Both in the same cycle: cnt[i] unchanged.
- Result return:
  - On res_valid, write res_data into FIFO[res_tag] and decrement inflight[res_tag]; cnt[res_tag] is unchanged.
  - rsp_valid[i] follows non-empty the cycle after the write (write-to-rsp_valid latency 1).
  - Writes to different FIFOs never collide (one result per cycle).
- FIFO:
  - Wrap-around pointers of clog2(RDEPTH)+1 bits.
  - Simultaneous write and read on a non-empty FIFO keeps occupancy constant.
  - Simultaneous write and read on an empty FIFO: the write lands, no read occurs, occupancy goes to 1.
  - rsp_data[i] holds the head entry; it is 0 when empty.
- err (sticky until rst), set on either of:
  - res_valid with res_tag >= NREQ;
  - res_valid with inflight[res_tag]==0.
  - The offending result is discarded; no credit or FIFO change.
- Fairness: under continuous requests from all NREQ requesters with free credit, each is granted exactly once per NREQ cycles, in order ptr, ptr+1, ...

Test Plan:
- Single op: req_valid[1]=1, a=7, b=6, unsigned, model latency 3 → req_ready[1]=1 at t0; mul_valid, mul_tag=1, mul_a=7 at t1; rsp_valid[1]=1 with rsp_data=42 at t5.
- All four requesting continuously, rsp_ready=1 → grants 0,1,2,3,0,... one per cycle; mul_valid stays 1; no err.
- Credit exhaustion: requester 2 valid, rsp_ready[2]=0, RDEPTH=4 → exactly 4 accepts, then req_ready[2]=0. Asserting rsp_ready[2] for 1 cycle → exactly one further accept.
- Signed: a=-3 (0xFFFFFFFD), b=5, signed=1 → rsp_data=0xFFFFFFFFFFFFFFF1. Same operands unsigned → 0x4FFFFFFF1.
- Simultaneous: the cycle requester 0 pops while being re-granted → cnt[0] unchanged. A res_valid into a FIFO being read keeps occupancy constant.
- Error/reset: inject res_valid with tag 3 and no outstanding op → err=1 next cycle, FIFO 3 empty. Assert rst with 2 ops in flight → all outputs reset; the late results set err and are not delivered.
